// File: rtl/serial_sub4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub4_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub4_sub_bit_slice.sv
// One full-adder slice with the b operand inverted, so it computes a + ~b + cin.
// Chaining the carry through a flop turns it into a serial subtractor.
module sub_bit_slice
  import serial_sub4_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic b_n;

  assign b_n  = ~b;
  assign s    = a ^ b_n ^ cin;
  assign cout = (a & b_n) | (a & cin) | (b_n & cin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: D = X - Y - BIN, one bit per clock, LSB first,
// with a start/done handshake and results held until the next completion.
module serial_sub4
  import serial_sub4_pkg::*;
#(
  parameter int N  = DEFAULT_W,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         v
);

  state_t        state, state_nx;
  logic          accept;
  logic          last;
  logic [CW-1:0] cnt;
  logic [N-1:0]  xs, ys, rs;
  logic          c;
  logic          s, cout;

  sub_bit_slice u_slice (
    .a   (xs[0]),
    .b   (ys[0]),
    .cin (c),
    .s   (s),
    .cout(cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CW'(N - 1)) begin
          last     = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        accept   = start;
        state_nx = start ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Carry flop starts at ~bin so the slice chain computes X + ~Y + ~BIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      xs   <= '0;
      ys   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      v    <= 1'b0;
    end else begin
      if (accept) begin
        xs  <= x;
        ys  <= y;
        c   <= ~bin;
        cnt <= '0;
      end else if (state == ST_RUN) begin
        xs  <= xs >> 1;
        ys  <= ys >> 1;
        rs  <= {s, rs[N-1:1]};
        c   <= cout;
        cnt <= cnt + CW'(1);
      end
      // On the last bit, c holds c_{N-1} and cout is c_N.
      if (last) begin
        d    <= {s, rs[N-1:1]};
        bout <= ~cout;
        v    <= c ^ cout;
      end
    end
  end

endmodule
